// File: rtl/gol_cell_engine.sv
// Game of Life cell engine: owns the ROWSxCOLS grid, programs it from buttons, and
// evolves one generation per tick with a one-cell-per-clock scan. Optional macro GOL_TORUS_EN.
module gol_cell_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 16,
  parameter int IDX_W = 7
) (
  input  logic                   clka,
  input  logic                   rst_n,
  input  logic [1:0]             game_state,
  input  logic                   btn0,
  input  logic                   btn1,
  input  logic                   tick,
  output logic [IDX_W-1:0]       cell_idx,
  output logic [ROWS*COLS-1:0]   grid,
  output logic                   busy,
  output logic                   gen_done,
  output logic [15:0]            gen_count
);

  localparam int N     = ROWS * COLS;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = IDX_W - COL_W;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_PROG = 2'b01;
  localparam logic [1:0] GS_RUN  = 2'b10;

  typedef enum logic [1:0] {E_IDLE, E_SCAN, E_COMMIT} estate_t;

  estate_t          estate_q, estate_d;
  logic [N-1:0]     grid_q, grid_d;
  logic [N-1:0]     next_buf_q, next_buf_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [15:0]      gen_count_q, gen_count_d;
  logic             gen_done_q, gen_done_d;

  // Power-of-two dimensions let coordinate truncation perform the torus wrap.
  function automatic logic [3:0] neighbor_count(input logic [N-1:0] g,
                                                input logic [IDX_W-1:0] idx);
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [IDX_W-1:0] nidx;
    logic [3:0]       cnt;
    logic             inb;
    int               r;
    int               c;
    row = idx[IDX_W-1:COL_W];
    col = idx[COL_W-1:0];
    cnt = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
          r    = int'(row) + dr;
          c    = int'(col) + dc;
          nidx = {ROW_W'(r), COL_W'(c)};
`ifdef GOL_TORUS_EN
          inb  = 1'b1;
`else
          inb  = (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
`endif
          cnt  = cnt + {3'b000, g[nidx] & inb};
        end
      end
    end
    return cnt;
  endfunction

  function automatic logic next_cell(input logic alive, input logic [3:0] cnt);
    return alive ? (cnt == 4'd2 || cnt == 4'd3) : (cnt == 4'd3);
  endfunction

  always_comb begin
    estate_d    = estate_q;
    grid_d      = grid_q;
    next_buf_d  = next_buf_q;
    cursor_d    = cursor_q;
    scan_idx_d  = scan_idx_q;
    gen_count_d = gen_count_q;
    gen_done_d  = 1'b0;
    case (game_state)
      GS_IDLE: begin
        estate_d    = E_IDLE;
        grid_d      = '0;
        cursor_d    = '0;
        scan_idx_d  = '0;
        gen_count_d = 16'd0;
      end
      GS_PROG: begin
        estate_d   = E_IDLE;
        scan_idx_d = '0;
        // Simultaneous presses cancel: no write and the cursor stays put.
        if (btn0 ^ btn1) begin
          grid_d[cursor_q] = btn1;
          cursor_d         = cursor_q + IDX_W'(1);
        end
      end
      default: begin
        case (estate_q)
          E_IDLE: begin
            if (game_state == GS_RUN && tick) begin
              estate_d   = E_SCAN;
              scan_idx_d = '0;
            end
          end
          E_SCAN: begin
            next_buf_d[scan_idx_q] = next_cell(grid_q[scan_idx_q],
                                               neighbor_count(grid_q, scan_idx_q));
            scan_idx_d = scan_idx_q + IDX_W'(1);
            if (scan_idx_q == IDX_W'(N - 1)) estate_d = E_COMMIT;
          end
          E_COMMIT: begin
            grid_d      = next_buf_q;
            gen_count_d = gen_count_q + 16'd1;
            gen_done_d  = 1'b1;
            estate_d    = E_IDLE;
          end
          default: estate_d = E_IDLE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      estate_q    <= E_IDLE;
      grid_q      <= '0;
      cursor_q    <= '0;
      scan_idx_q  <= '0;
      gen_count_q <= 16'd0;
      gen_done_q  <= 1'b0;
    end else begin
      estate_q    <= estate_d;
      grid_q      <= grid_d;
      cursor_q    <= cursor_d;
      scan_idx_q  <= scan_idx_d;
      gen_count_q <= gen_count_d;
      gen_done_q  <= gen_done_d;
    end
  end

  // Scratch buffer is fully rewritten before every commit, so it needs no reset.
  always_ff @(posedge clka) begin
    next_buf_q <= next_buf_d;
  end

  assign grid      = grid_q;
  assign busy      = (estate_q != E_IDLE);
  assign gen_done  = gen_done_q;
  assign gen_count = gen_count_q;
  assign cell_idx  = (game_state == GS_PROG) ? cursor_q : scan_idx_q;

endmodule

// File: doc/gol_cell_engine.md
# gol_cell_engine

Cell-array engine for the Game of Life design. It consumes the 2-bit game state from the game-control FSM and owns the 8×16 cell grid. In PROGRAM it writes cells at a cursor driven by the two buttons. In RUN it computes one new generation per `tick` by scanning all 128 cells sequentially, one cell per clock. It drives `cell_idx` and the grid image consumed by the display logic.

## Interface
- `ROWS`, default 8: grid rows; `ROWS*COLS` must equal 2^`IDX_W`.
- `COLS`, default 16: grid columns, power of two.
- `IDX_W`, default 7: cell index width; index = row*COLS + col.
- `clka` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `game_state` input 2: 00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE.
- `btn0` input 1: one-cycle pulse, pre-synchronized; write dead cell at cursor.
- `btn1` input 1: one-cycle pulse, pre-synchronized; write live cell at cursor.
- `tick` input 1: one-cycle generation strobe.
- `cell_idx` output IDX_W: cursor in PROGRAM, scan index otherwise.
- `grid` output ROWS*COLS: current generation; bit i = cell i, 1 = live.
- `busy` output 1: a generation scan/commit is in progress.
- `gen_done` output 1: one-cycle pulse when a new generation is committed.
- `gen_count` output 16: generations committed since last IDLE; wraps at 0xFFFF→0.

## Operation
- Reset: `grid`=0, `cell_idx`=0, cursor=0, scan_idx=0, `busy`=0, `gen_done`=0, `gen_count`=0, engine state E_IDLE.
- Engine states: E_IDLE, E_SCAN, E_COMMIT.
- game_state IDLE, every cycle:
  - grid, cursor, scan_idx and gen_count all cleared.
  - Engine forced to E_IDLE.
  - Any scan in progress is aborted.
- game_state PROGRAM:
  - Scan aborted, engine forced to E_IDLE.
  - btn1 alone: grid[cursor]<=1, cursor+1.
  - btn0 alone: grid[cursor]<=0, cursor+1.
  - Both buttons in the same cycle: no write, no advance.
  - Cursor wraps from 127 to 0.
- game_state RUN, engine in E_IDLE, tick=1: go to E_SCAN, scan_idx=0.
  - Ticks while `busy`=1 are ignored; they are not queued.
- E_SCAN, each cycle:
  - next_buf[scan_idx] <= rule(grid, scan_idx); scan_idx+1.
  - Neighbors are read from `grid`, which stays unchanged during the scan.
  - After index 127 is written: scan_idx wraps to 0, go to E_COMMIT.
- rule: live cell survives with 2 or 3 live neighbors; dead cell is born with exactly 3; otherwise the cell is dead. The neighbor count is 0..8 (4 bits).
- E_COMMIT, one cycle:
  - grid <= next_buf, gen_count+1, gen_done=1 next cycle.
  - Then return to E_IDLE.
- game_state PAUSE: an in-flight scan/commit completes normally; new ticks are ignored.
- Buttons are ignored outside PROGRAM.
- Cursor is held across RUN/PAUSE.
- game_state 10↔11 transitions never disturb grid contents.

## Timing
- Tick sampled at edge E0.
- E_SCAN occupies edges E1..E128.
- E_COMMIT occurs at edge E129. New `grid`, incremented `gen_count` and `gen_done`=1 are visible after E129.
- `busy`=1 from after E0 through after E128, and 0 after E129.
- A tick is accepted again at edge E129+1: 130-cycle minimum generation period.
- Programming write is visible on `grid` and `cell_idx` one cycle after the button pulse.
- IDLE takes effect on the first edge at which it is sampled, including mid-scan and mid-commit; the commit is then suppressed.
- Async reset overrides everything, at any time.

## Configuration
- `GOL_TORUS_EN` defined: toroidal topology.
  - Row and column neighbor coordinates wrap modulo ROWS/COLS.
  - Row 0 neighbors row 7; column 0 neighbors column 15.
- `GOL_TORUS_EN` undefined: bounded grid; off-grid neighbors count as dead.

## Test plan
- Program blinker (PROGRAM; btn1 at cursor 52,53,54 with btn0 elsewhere), RUN, tick:
  - After 130 cycles: grid has bits {37,53,69} only, gen_count=1, one gen_done pulse.
  - Second tick restores bits {52,53,54}.
- Block {0,1,16,17} with 5 ticks spaced 130 cycles apart: grid unchanged, gen_count=5.
- Bits {15,0,1}, one tick:
  - With GOL_TORUS_EN: grid = bits {112,0,16}.
  - Without GOL_TORUS_EN: grid = 0.
- Cursor behaviour in PROGRAM:
  - 128 btn0 pulses: cell_idx returns to 0.
  - btn0+btn1 in the same cycle: cell_idx and grid unchanged.
- Tick during scan (cycle 50): ignored, gen_count increments once.
- PAUSE at cycle 60 of a scan: commit still occurs at E129.
- IDLE at cycle 60 of a scan: no gen_done, grid=0 and gen_count=0 one cycle later.
- rst_n low mid-scan: all outputs return to their reset values asynchronously.
